hard_decode_ctrl: RTL and testbench
===================================

Name: hard_decode_ctrl

Overview:
Sequencing controller for the combinational hard_decoder. It holds the code configuration (N, n, a) and accepts received words over a valid/ready stream. It drives each word into the decoder, waits a fixed settle time, and captures the decoded word into an output buffer drained by a valid/ready consumer. It sits between the channel-read front end and downstream consumers. The decoder itself is outside this block and connects through the dec_* ports.

Parameters:
W, 17, width of received and decoded words
CW, 32, width of the N / n / a configuration fields
DEC_LAT, 1, cycles between driving dec_* and sampling dec_out (legal range >= 1)
DEPTH, 4, output buffer entries (power of two, >= 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  configuration write strobe
cfg_N  in  CW  code length N
cfg_n  in  CW  information length n
cfg_a  in  CW  syndrome parameter a
cfg_err  out  1  the applied configuration is illegal
in_valid  in  1  received word is valid
in_ready  out  1  controller accepts a word
in_word  in  W  received word
dec_received  out  W  decoder input word (registered)
dec_N  out  CW  decoder N (registered, active config)
dec_n  out  CW  decoder n (registered, active config)
dec_a  out  CW  decoder a (registered, active config)
dec_out  in  W  decoder result
out_valid  out  1  buffer not empty
out_ready  in  1  consumer takes the head word
out_word  out  W  head of output buffer
word_cnt  out  16  words decoded since the last config apply; wraps modulo 2^16

Behaviour:
- Asynchronous reset forces: state IDLE, cfg_valid=0, cfg_pend=0, cfg_err=0, all dec_* outputs = 0, buffer empty (out_valid=0, out_word=0), word_cnt=0, in_ready=0.
- Shadow config: cfg_we writes cfg_N/n/a into the shadow registers and sets cfg_pend, in any state. The last write wins.
- Apply: in IDLE with cfg_pend=1, copy shadow to dec_N/n/a on the next edge and clear cfg_pend. cfg_valid=1. word_cnt=0. cfg_err is set if N==0, N>W, n==0 or n>N; otherwise it is cleared. a is not checked.
- in_ready = IDLE && cfg_valid && !cfg_err && !cfg_pend && (count < DEPTH). This is combinational from registered state only.
- A word accepted in the same cycle as a cfg_we uses the old active configuration.
- State machine (IDLE, WAIT):
  - IDLE -> WAIT on in_valid && in_ready. At that edge: dec_received <= in_word, wait_cnt <= DEC_LAT.
  - WAIT decrements wait_cnt each edge. When wait_cnt==1: push dec_out into the buffer, word_cnt++, return to IDLE.
- Latency: word accepted at edge t is captured at edge t+DEC_LAT. out_valid is high from t+DEC_LAT if the buffer was empty.
- Throughput: one word per DEC_LAT+1 cycles. in_ready is low in WAIT.
- Backpressure: because count < DEPTH is checked at accept and only one word is in flight, a capture never finds the buffer full. No word is ever dropped.
- Buffer: FIFO. A pop occurs on out_valid && out_ready. Push and pop in the same cycle leave count unchanged. Read/write pointers wrap modulo DEPTH. out_word holds the head and is 0 when empty.
- dec_received holds its value after capture until the next accept.
- Reset mid-WAIT or with a non-empty buffer discards all data and configuration.
- in_valid while in_ready=0 has no effect. The producer must hold in_word until accepted.

Test Plan:
- Reset, then cfg_we with N=4, n=3, a=2, then in_word=17'h00005. The decoder stub returns received^17'h0001F. Required: dec_N=4, dec_n=3, dec_a=2; out_word=17'h0001A with out_valid exactly DEC_LAT edges after accept; word_cnt=1.
- Back-to-back words 17'h00005 and 17'h00003 with in_valid held high and out_ready=1. Required: in_ready toggles 1,0,1 (DEC_LAT=1); outputs 17'h0001A then 17'h0001C in order; word_cnt=2.
- out_ready=0, stream 6 words with DEPTH=4. Required: in_ready stays low after the 4th capture; count=4; after popping one, the 5th word is accepted; no loss or reordering.
- cfg_we N=4, n=5, a=7 (n>N). Required: cfg_err=1, in_ready=0. Then cfg_we N=4, n=4, a=6: cfg_err=0, in_ready=1, word_cnt=0.
- cfg_we N=4, n=3, a=3 during WAIT. Required: the in-flight word completes with a=2 on dec_a; new config is applied the cycle after IDLE is entered; in_ready stays low until then.
- Assert rst mid-WAIT with 2 words buffered. Required: out_valid=0, dec_* = 0, cfg_valid=0 (in_ready=0) immediately and asynchronously; after release no output appears until a new cfg_we.

Source files
------------

// File: rtl/hard_decode_ctrl.sv
// hard_decode_ctrl: sequences received words through the external combinational
// hard decoder. It holds the code configuration (shadow + active copy), drives one
// word at a time into dec_*, waits DEC_LAT cycles, and captures dec_out into a
// small output FIFO that a valid/ready consumer drains.
module hard_decode_ctrl #(
    parameter int W       = 17,
    parameter int CW      = 32,
    parameter int DEC_LAT = 1,
    parameter int DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_N,
    input  logic [CW-1:0] cfg_n,
    input  logic [CW-1:0] cfg_a,
    output logic          cfg_err,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_word,
    output logic [W-1:0]  dec_received,
    output logic [CW-1:0] dec_N,
    output logic [CW-1:0] dec_n,
    output logic [CW-1:0] dec_a,
    input  logic [W-1:0]  dec_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_word,
    output logic [15:0]   word_cnt
);
    localparam int AW  = $clog2(DEPTH);
    localparam int WCW = (DEC_LAT < 2) ? 1 : $clog2(DEC_LAT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state;
    logic            cfg_valid;
    logic            cfg_pend;
    logic [CW-1:0]   sh_N, sh_n, sh_a;
    logic [WCW-1:0]  wait_cnt;
    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;

    logic            accept, capture, pop;
    logic [CW-1:0]   wmax;

    assign wmax      = CW'(W);
    assign in_ready  = (state == IDLE) && cfg_valid && !cfg_err && !cfg_pend &&
                       (count < (AW+1)'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign capture   = (state == WAIT) && (wait_cnt == WCW'(1));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_word  = out_valid ? mem[rd_ptr] : '0;

    // Shadow config: any write is held here until the FSM is idle to apply it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_N <= '0;
            sh_n <= '0;
            sh_a <= '0;
        end else if (cfg_we) begin
            sh_N <= cfg_N;
            sh_n <= cfg_n;
            sh_a <= cfg_a;
        end
    end

    // Control FSM: applies pending config when idle, otherwise launches and times words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cfg_valid    <= 1'b0;
            cfg_pend     <= 1'b0;
            cfg_err      <= 1'b0;
            dec_received <= '0;
            dec_N        <= '0;
            dec_n        <= '0;
            dec_a        <= '0;
            wait_cnt     <= '0;
            word_cnt     <= '0;
        end else begin
            // A write landing on the apply edge stays pending and is applied next.
            if (cfg_we)
                cfg_pend <= 1'b1;
            else if (state == IDLE && cfg_pend)
                cfg_pend <= 1'b0;

            case (state)
                IDLE: begin
                    if (cfg_pend) begin
                        dec_N     <= sh_N;
                        dec_n     <= sh_n;
                        dec_a     <= sh_a;
                        cfg_valid <= 1'b1;
                        word_cnt  <= '0;
                        cfg_err   <= (sh_N == '0) || (sh_N > wmax) ||
                                     (sh_n == '0) || (sh_n > sh_N);
                    end else if (accept) begin
                        dec_received <= in_word;
                        wait_cnt     <= WCW'(DEC_LAT);
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WCW'(1)) begin
                        word_cnt <= word_cnt + 16'd1;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - WCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output FIFO pointers/occupancy; accept gating guarantees a capture never sees it full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (capture) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({capture, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the entry is not occupied.
    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr] <= dec_out;
    end
endmodule

// File: tb/tb_hard_decode_ctrl.sv
// Directed bench for hard_decode_ctrl with a decoder stub (received ^ 'h1F) and a
// scoreboard queue of expected output words checked as the consumer pops them.
module tb_hard_decode_ctrl;
    localparam int W = 17, CW = 32, DEC_LAT = 1, DEPTH = 4;

    logic          clk = 0, rst = 0;
    logic          cfg_we = 0;
    logic [CW-1:0] cfg_N = 0, cfg_n = 0, cfg_a = 0;
    logic          cfg_err;
    logic          in_valid = 0, in_ready;
    logic [W-1:0]  in_word = 0;
    logic [W-1:0]  dec_received, dec_out;
    logic [CW-1:0] dec_N, dec_n, dec_a;
    logic          out_valid, out_ready = 0;
    logic [W-1:0]  out_word;
    logic [15:0]   word_cnt;

    int checks = 0, errors = 0;
    logic [W-1:0] sb[$];

    hard_decode_ctrl #(.W(W), .CW(CW), .DEC_LAT(DEC_LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_N(cfg_N), .cfg_n(cfg_n),
        .cfg_a(cfg_a), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .dec_received(dec_received), .dec_N(dec_N), .dec_n(dec_n),
        .dec_a(dec_a), .dec_out(dec_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .word_cnt(word_cnt)
    );

    // Decoder stub
    assign dec_out = dec_received ^ 17'h0001F;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [CW-1:0] n_, input logic [CW-1:0] k_, input logic [CW-1:0] a_);
        cfg_we = 1; cfg_N = n_; cfg_n = k_; cfg_a = a_;
        tick();
        cfg_we = 0;
        tick();  // apply edge
    endtask

    // Offer a word, wait (bounded) for acceptance, then let it be captured.
    task automatic send(input logic [W-1:0] w);
        int n = 0;
        sb.push_back(w ^ 17'h0001F);
        in_valid = 1; in_word = w;
        while (!in_ready && n < 50) begin tick(); n++; end
        check("accept_timeout", 32'(n < 50), 32'd1);
        if (n >= 50) void'(sb.pop_back());
        tick();
        in_valid = 0;
        tick();
    endtask

    // Scoreboard monitor: compare every popped head word against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) check("unexpected_out", {15'd0, out_word}, 32'hDEAD);
            else check("out_word", {15'd0, out_word}, {15'd0, sb.pop_front()});
        end
    end

    initial begin
        // Reset state
        rst = 1;
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_word", 32'(out_word), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_word_cnt", 32'(word_cnt), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        check("rst_dec_N", dec_N, 0);
        rst = 0;
        tick();

        // Basic decode, latency check with consumer stalled
        cfg_we = 1; cfg_N = 4; cfg_n = 3; cfg_a = 2;
        tick();
        cfg_we = 0;
        check("pend_in_ready", 32'(in_ready), 0);
        tick();
        check("dec_N", dec_N, 4);
        check("dec_n", dec_n, 3);
        check("dec_a", dec_a, 2);
        check("apply_in_ready", 32'(in_ready), 1);
        sb.push_back(17'h0001A);
        in_valid = 1; in_word = 17'h00005;
        tick();
        in_valid = 0;
        check("wait_in_ready", 32'(in_ready), 0);
        check("wait_out_valid", 32'(out_valid), 0);
        check("dec_received", 32'(dec_received), 32'h5);
        tick();
        check("lat_out_valid", 32'(out_valid), 1);
        check("word_cnt1", 32'(word_cnt), 1);
        out_ready = 1;
        tick();
        check("drained", 32'(out_valid), 0);

        // Back-to-back with in_valid held high
        write_cfg(4, 3, 2);
        check("reapply_cnt", 32'(word_cnt), 0);
        sb.push_back(17'h0001A);
        sb.push_back(17'h0001C);
        in_valid = 1; in_word = 17'h00005;
        check("b2b_rdy0", 32'(in_ready), 1);
        tick();
        check("b2b_rdy1", 32'(in_ready), 0);
        tick();
        check("b2b_rdy2", 32'(in_ready), 1);
        in_word = 17'h00003;
        tick();
        in_valid = 0;
        tick();
        check("word_cnt2", 32'(word_cnt), 2);
        tick();

        // Fill the buffer with the consumer stalled
        out_ready = 0;
        for (int i = 0; i < 4; i++) send(17'h00100 + 17'(i));
        in_valid = 1; in_word = 17'h00104;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_in_ready", 32'(in_ready), 0);
        end
        check("full_out_valid", 32'(out_valid), 1);
        out_ready = 1;
        tick();
        out_ready = 0;
        check("after_pop_ready", 32'(in_ready), 1);
        sb.push_back(17'h00104 ^ 17'h0001F);
        tick();
        in_valid = 0;
        tick();
        check("refull_in_ready", 32'(in_ready), 0);
        out_ready = 1;
        send(17'h00105);
        for (int i = 0; i < 6; i++) tick();
        check("fill_sb_empty", sb.size(), 0);
        check("fill_out_valid", 32'(out_valid), 0);

        // Configuration legality
        write_cfg(4, 5, 7);
        check("err_n_gt_N", 32'(cfg_err), 1);
        check("err_in_ready", 32'(in_ready), 0);
        write_cfg(4, 4, 6);
        check("ok_cfg_err", 32'(cfg_err), 0);
        check("ok_in_ready", 32'(in_ready), 1);
        check("ok_word_cnt", 32'(word_cnt), 0);
        check("ok_dec_a", dec_a, 6);
        write_cfg(18, 3, 0);
        check("err_N_gt_W", 32'(cfg_err), 1);
        write_cfg(0, 0, 0);
        check("err_N_zero", 32'(cfg_err), 1);
        write_cfg(17, 17, 1);
        check("ok_N_eq_W", 32'(cfg_err), 0);

        // Config write during WAIT
        write_cfg(4, 3, 2);
        sb.push_back(17'h00007 ^ 17'h0001F);
        in_valid = 1; in_word = 17'h00007;
        tick();
        in_valid = 0;
        cfg_we = 1; cfg_N = 4; cfg_n = 3; cfg_a = 3;
        check("inflight_dec_a", dec_a, 2);
        tick();
        cfg_we = 0;
        check("cap_dec_a", dec_a, 2);
        check("pend_block_ready", 32'(in_ready), 0);
        tick();
        check("new_dec_a", dec_a, 3);
        check("new_in_ready", 32'(in_ready), 1);
        tick();
        check("wait_sb_empty", sb.size(), 0);

        // Asynchronous reset mid-WAIT with two words buffered
        out_ready = 0;
        send(17'h00011);
        send(17'h00012);
        in_valid = 1; in_word = 17'h00013;
        tick();
        check("pre_rst_valid", 32'(out_valid), 1);
        #2 rst = 1;
        #1;
        sb.delete();
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_in_ready", 32'(in_ready), 0);
        check("arst_dec_N", dec_N, 0);
        check("arst_dec_a", dec_a, 0);
        check("arst_dec_rx", 32'(dec_received), 0);
        check("arst_word_cnt", 32'(word_cnt), 0);
        #10 rst = 0;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_ready", 32'(in_ready), 0);
            check("post_rst_valid", 32'(out_valid), 0);
        end
        in_valid = 0;
        write_cfg(4, 3, 2);
        check("recfg_ready", 32'(in_ready), 1);
        send(17'h00000);
        tick();
        check("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
